// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Definitions shared by the instruction-fetch block:
//   - fetch_state_e : sequencer states (IDLE / RUN / HALT)
//   - PC_W_DEF      : default program-counter width
//   - CNT_W_DEF     : default retired-instruction counter width
//   - TARGET        : 4-entry branch/jump target table, indexed by TargSel
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;
    localparam int N_TARG    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Table entries are written at the default PC width. The lookup
    // resizes them to the instantiated PC width.
    localparam logic [PC_W_DEF-1:0] TARGET [N_TARG] = '{
        10'd0,
        10'd16,
        10'd64,
        10'd255
    };

endpackage

// File: rtl/instr_fetch_lut_targ.sv
// ---------------------------------------------------------------------------
// lut_targ
// Purely combinational branch-target lookup into the TARGET table.
// Parameters:
//   PC_W    : width of the returned target address
// Ports:
//   TargSel : in  [1:0]       table index
//   Target  : out [PC_W-1:0]  target address
// ---------------------------------------------------------------------------
module lut_targ
    import instr_fetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [1:0]      TargSel,
    output logic [PC_W-1:0] Target
);

    always_comb begin
        Target = PC_W'(TARGET[TargSel]);
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Program-counter sequencer with an IDLE / RUN / HALT control FSM.
//
// Parameters:
//   PC_W     : program-counter width (instruction memory depth 2**PC_W)
//   CNT_W    : retired-instruction counter width
//
// Ports:
//   Clk      : in   clock, rising edge
//   Reset_n  : in   asynchronous active-low reset
//   Start    : in   begin execution at address 0 (accepted in IDLE and HALT)
//   Stall    : in   freeze fetch while in RUN
//   Jump     : in   unconditional redirect to TARGET[TargSel]
//   BranchEn : in   conditional redirect, qualified by Taken
//   Taken    : in   ALU condition flag
//   TargSel  : in   [1:0] target table index
//   Ack      : in   program finished, go to HALT
//   ProgCtr  : out  [PC_W-1:0] current instruction address
//   Running  : out  registered (state == RUN)
//   Done     : out  registered (state == HALT)
//   InstrCnt : out  [CNT_W-1:0] instructions retired since the last Start
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Jump,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic [1:0]        TargSel,
    input  logic              Ack,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  InstrCnt
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [PC_W-1:0]  targ_addr;
    logic [CNT_W-1:0] cnt_inc;

    lut_targ #(
        .PC_W    (PC_W)
    ) u_lut_targ (
        .TargSel (TargSel),
        .Target  (targ_addr)
    );

    // Retired count saturates rather than wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // A stalled cycle retires nothing and ignores every request.
                if (!Stall) begin
                    cnt_d = cnt_inc;
                    if (Ack) begin
                        state_d = ST_HALT;
                    end else if (Jump || (BranchEn && Taken)) begin
                        pc_d = targ_addr;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        // Status flags are decoded from the next state so that, once
        // registered, they line up with state_q.
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign InstrCnt = cnt_q;
    assign Running  = running_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed test of instr_fetch with hand-computed expected values.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic             Stall;
    logic             Jump;
    logic             BranchEn;
    logic             Taken;
    logic [1:0]       TargSel;
    logic             Ack;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCnt;

    int n_pass;
    int n_total;

    instr_fetch #(
        .PC_W     (PC_W),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Stall    (Stall),
        .Jump     (Jump),
        .BranchEn (BranchEn),
        .Taken    (Taken),
        .TargSel  (TargSel),
        .Ack      (Ack),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done),
        .InstrCnt (InstrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start    = 1'b0;
        Stall    = 1'b0;
        Jump     = 1'b0;
        BranchEn = 1'b0;
        Taken    = 1'b0;
        TargSel  = 2'd0;
        Ack      = 1'b0;
    endtask

    task automatic free_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_state(input string tag, input logic [PC_W-1:0] pc,
                             input logic [CNT_W-1:0] cnt, input logic run, input logic dn);
        chk({tag, ".pc"},  32'(ProgCtr),  32'(pc));
        chk({tag, ".cnt"}, 32'(InstrCnt), 32'(cnt));
        chk({tag, ".run"}, 32'(Running),  32'(run));
        chk({tag, ".done"}, 32'(Done),    32'(dn));
    endtask

    task automatic reset_and_start();
        idle_inputs();
        Reset_n = 1'b0;
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        Reset_n = 1'b0;
        cyc();
        cyc();
        chk_state("reset", 10'd0, 16'd0, 1'b0, 1'b0);

        // Start ignored? No: IDLE with Start goes to RUN at 0.
        Reset_n = 1'b1;
        cyc();
        chk_state("idle_hold", 10'd0, 16'd0, 1'b0, 1'b0);
        Start = 1'b1;
        cyc();
        chk_state("start", 10'd0, 16'd0, 1'b1, 1'b0);

        // Five free cycles: 1..5.
        for (int i = 1; i <= 5; i++) begin
            free_cycles(1);
            chk("free.pc", 32'(ProgCtr), 32'(i));
        end
        chk_state("free5", 10'd5, 16'd5, 1'b1, 1'b0);

        // Jump at PC 7 to TARGET[2]=64, then 65.
        free_cycles(2);
        chk("pre_jump.pc", 32'(ProgCtr), 32'd7);
        Jump = 1'b1; TargSel = 2'd2;
        cyc();
        chk_state("jump", 10'd64, 16'd8, 1'b1, 1'b0);
        free_cycles(1);
        chk_state("after_jump", 10'd65, 16'd9, 1'b1, 1'b0);

        // Branch at PC 9: not taken -> 10, taken -> 255.
        reset_and_start();
        free_cycles(9);
        chk("pre_br.pc", 32'(ProgCtr), 32'd9);
        BranchEn = 1'b1; TargSel = 2'd3; Taken = 1'b0;
        cyc();
        chk_state("br_ntaken", 10'd10, 16'd10, 1'b1, 1'b0);
        Taken = 1'b1;
        cyc();
        chk_state("br_taken", 10'd255, 16'd11, 1'b1, 1'b0);

        // Jump to 16, climb to 20, stall 3 cycles with Jump held.
        idle_inputs();
        Jump = 1'b1; TargSel = 2'd1;
        cyc();
        chk("jump16.pc", 32'(ProgCtr), 32'd16);
        free_cycles(4);
        chk_state("pre_stall", 10'd20, 16'd16, 1'b1, 1'b0);
        Stall = 1'b1; Jump = 1'b1; TargSel = 2'd2; Ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_state("stall", 10'd20, 16'd16, 1'b1, 1'b0);
        end
        free_cycles(1);
        chk_state("unstall", 10'd21, 16'd17, 1'b1, 1'b0);

        // Ack + Jump at PC 30 -> HALT holding 30.
        free_cycles(9);
        chk("pre_ack.pc", 32'(ProgCtr), 32'd30);
        Ack = 1'b1; Jump = 1'b1; TargSel = 2'd2;
        cyc();
        chk_state("halt", 10'd30, 16'd27, 1'b0, 1'b1);
        BranchEn = 1'b1; Taken = 1'b1; Ack = 1'b0;
        cyc();
        cyc();
        chk_state("halt_hold", 10'd30, 16'd27, 1'b0, 1'b1);
        idle_inputs();
        Start = 1'b1;
        cyc();
        chk_state("restart", 10'd0, 16'd0, 1'b1, 1'b0);

        // Start while running is ignored.
        free_cycles(1);
        Start = 1'b1;
        cyc();
        chk_state("start_in_run", 10'd2, 16'd2, 1'b1, 1'b0);

        // Jump to 255, then 768 increments reach 1023, one more wraps to 0.
        idle_inputs();
        Jump = 1'b1; TargSel = 2'd3;
        cyc();
        free_cycles(768);
        chk_state("pc_max", 10'd1023, 16'd771, 1'b1, 1'b0);
        free_cycles(1);
        chk_state("pc_wrap", 10'd0, 16'd772, 1'b1, 1'b0);

        // Asynchronous reset mid-RUN, between clock edges.
        free_cycles(3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_state("async_rst", 10'd0, 16'd0, 1'b0, 1'b0);
        #1;
        Reset_n = 1'b1;
        cyc();
        chk_state("rel_idle", 10'd0, 16'd0, 1'b0, 1'b0);
        free_cycles(2);
        chk_state("rel_wait", 10'd0, 16'd0, 1'b0, 1'b0);
        Start = 1'b1;
        cyc();
        free_cycles(1);
        chk_state("rel_start", 10'd1, 16'd1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 10, SHALL set program-counter width (instruction memory depth 2**PC_W).
REQ-002 Parameter CNT_W, default 16, SHALL set the executed-instruction counter width.
REQ-003 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Start  input  1  single-cycle request to begin program execution from address 0.
REQ-006 Stall  input  1  hold request from downstream; freezes fetch while high.
REQ-007 Jump  input  1  unconditional redirect request from the control decoder.
REQ-008 BranchEn  input  1  conditional redirect request from the control decoder.
REQ-009 Taken  input  1  ALU condition flag qualifying BranchEn.
REQ-010 TargSel  input  2  index into the branch-target table.
REQ-011 Ack  input  1  decoder "done with program" indication.
REQ-012 ProgCtr  output  PC_W  current instruction address to instruction memory.
REQ-013 Running  output  1  high while state is RUN.
REQ-014 Done  output  1  high while state is HALT.
REQ-015 InstrCnt  output  CNT_W  count of instructions retired since last Start.

Function
REQ-016 States SHALL be IDLE, RUN, HALT.
REQ-017 IDLE: Start=1 SHALL go to RUN with ProgCtr=0 and InstrCnt=0 on the same edge; all other inputs ignored.
REQ-018 RUN, Stall=1: ProgCtr, InstrCnt and state SHALL hold; Jump, BranchEn, Ack and Start are ignored.
REQ-019 RUN, Stall=0: next-PC priority SHALL be Ack > Jump > (BranchEn & Taken) > ProgCtr+1.
REQ-020 Ack=1 (unstalled, RUN) SHALL go to HALT with ProgCtr held and InstrCnt incremented once.
REQ-021 Jump=1 SHALL load ProgCtr with TARGET[TargSel].
REQ-022 BranchEn=1 and Taken=1 SHALL load ProgCtr with TARGET[TargSel]; BranchEn=1 with Taken=0 SHALL increment.
REQ-023 Increment SHALL wrap modulo 2**PC_W (all-ones -> 0) without changing state.
REQ-024 Each unstalled RUN cycle SHALL increment InstrCnt by 1, saturating at all-ones.
REQ-025 Start in RUN SHALL be ignored; Start in HALT SHALL behave as in IDLE (restart at 0, counter cleared).
REQ-026 HALT SHALL hold ProgCtr and InstrCnt until Start or reset.
REQ-027 Redirect latency SHALL be one cycle: the address on the edge after the Jump/branch cycle is the target.
REQ-028 Running and Done SHALL be registered decodes of state, never both high.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force state IDLE, ProgCtr=0, InstrCnt=0, Running=0, Done=0.
REQ-030 Reset asserted mid-RUN SHALL abandon the program; after release the block waits in IDLE for Start.
REQ-031 Release SHALL be synchronous-safe: no state change on the first edge after deassertion unless Start=1.

Structure
REQ-032 Shared package SHALL hold the state enum, PC_W/CNT_W defaults and the 4-entry TARGET constant table (0: 10'd0, 1: 10'd16, 2: 10'd64, 3: 10'd255).
REQ-033 Target lookup SHALL be a combinational sub-module lut_targ (TargSel in, PC_W target out).
REQ-034 Next-PC selection and FSM SHALL live in instr_fetch; no memory instantiated inside.

Verification
REQ-035 Reset, Start pulse, 5 free cycles -> ProgCtr 0,1,2,3,4,5; Running=1; InstrCnt=5.
REQ-036 At ProgCtr=7 assert Jump with TargSel=2 -> next ProgCtr=64, then 65.
REQ-037 BranchEn=1, TargSel=3, Taken=0 at ProgCtr=9 -> 10; repeat with Taken=1 -> 255.
REQ-038 Stall high 3 cycles at ProgCtr=20 with Jump=1 -> ProgCtr stays 20, InstrCnt unchanged, Jump ignored.
REQ-039 Ack and Jump together at ProgCtr=30 -> HALT, ProgCtr=30, Done=1; later Start -> ProgCtr=0, InstrCnt=0.
REQ-040 ProgCtr=1023 increments -> 0; Reset_n pulsed mid-RUN -> immediately IDLE, all outputs 0.
